// File: rtl/mem_lsu.sv
// Memory stage load/store unit: bus handshake, store lane alignment, load extraction and WB registering.
// Optional misaligned-access trap is enabled with `define MEM_MISALIGN_CHK_EN.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_rd_wen_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_data_i,
    input  logic [2:0]  ex_mem_size_i,
    input  logic        ex_mem_we_i,
    input  logic        ex_mem_re_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_rd_data_o,
    output logic        wb_rd_wen_o,
    output logic        hold_flag_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o
);

    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned CW      = (TO_LAST < 2) ? 1 : $clog2(TO_LAST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    ld_size_q, ld_size_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic          ld_wen_q, ld_wen_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_wen_q, wb_wen_d;
    logic          err_q, err_d;
    logic          hold;
    logic          mem_op_c, aligned_c, timeout_hit_c;
    logic [1:0]    off_c;

    // Byte enables shared by loads and stores; undefined sizes fall into the word case.
    function automatic logic [3:0] lane_be(input logic [2:0] sz, input logic [1:0] off);
        case (sz[1:0])
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] sz, input logic [31:0] d);
        case (sz[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] sz, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = rd;
        endcase
    endfunction

    assign mem_op_c      = ex_mem_re_i | ex_mem_we_i;
    assign off_c         = ex_mem_addr_i[1:0];
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

`ifdef MEM_MISALIGN_CHK_EN
    logic        mis_q, mis_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    assign aligned_c = !(((ex_mem_size_i[1:0] == 2'b01) && off_c[0]) ||
                         (ex_mem_size_i[1] && (off_c != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q      <= 1'b0;
            mis_addr_q <= 32'd0;
        end else begin
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    // Misaligned request in IDLE: flag and capture the address, no bus access.
    always_comb begin
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
        if (state_q == IDLE && mem_op_c && !aligned_c) begin
            mis_d      = 1'b1;
            mis_addr_d = ex_mem_addr_i;
        end
    end

    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
`else
    assign aligned_c       = 1'b1;
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            ld_size_q <= 3'd0;
            ld_off_q  <= 2'd0;
            ld_rd_q   <= 5'd0;
            ld_wen_q  <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            wb_wen_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_rd_q   <= ld_rd_d;
            ld_wen_q  <= ld_wen_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_wen_q  <= wb_wen_d;
            err_q     <= err_d;
        end
    end

    // Next state, next registered outputs and the combinational stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_rd_d   = ld_rd_q;
        ld_wen_d  = ld_wen_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_wen_d  = 1'b0;
        err_d     = 1'b0;
        hold      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_op_c) begin
                    wb_addr_d = ex_rd_addr_i;
                    wb_data_d = ex_rd_data_i;
                    wb_wen_d  = ex_rd_wen_i;
                end else if (aligned_c) begin
                    hold      = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = ex_mem_we_i;
                    addr_d    = {ex_mem_addr_i[31:2], 2'b00};
                    be_d      = lane_be(ex_mem_size_i, off_c);
                    wdata_d   = lane_wdata(ex_mem_size_i, ex_mem_data_i);
                    ld_size_d = ex_mem_size_i;
                    ld_off_d  = off_c;
                    ld_rd_d   = ex_rd_addr_i;
                    ld_wen_d  = ex_rd_wen_i;
                end
            end
            BUSY: begin
                if (dbus_ack_i || timeout_hit_c) begin
                    // Ack takes priority over a coincident timeout.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = !dbus_ack_i;
                    if (!we_q) begin
                        wb_addr_d = ld_rd_q;
                        wb_data_d = dbus_ack_i ? load_ext(ld_size_q, ld_off_q, dbus_rdata_i) : 32'd0;
                        wb_wen_d  = ld_wen_q;
                    end
                end else begin
                    hold  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;
    assign wb_rd_addr_o = wb_addr_q;
    assign wb_rd_data_o = wb_data_q;
    assign wb_rd_wen_o  = wb_wen_q;
    assign bus_err_o    = err_q;
    assign hold_flag_o  = hold;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (TIMEOUT=4): pass-through, store lanes, load extension, timeout, reset, misalign.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        ex_rd_wen_i;
    logic [31:0] ex_mem_addr_i;
    logic [31:0] ex_mem_data_i;
    logic [2:0]  ex_mem_size_i;
    logic        ex_mem_we_i;
    logic        ex_mem_re_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        wb_rd_wen_o;
    logic        hold_flag_o;
    logic        bus_err_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    int tests = 0;
    int fails = 0;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wen_i(ex_rd_wen_i),
        .ex_mem_addr_i(ex_mem_addr_i), .ex_mem_data_i(ex_mem_data_i), .ex_mem_size_i(ex_mem_size_i),
        .ex_mem_we_i(ex_mem_we_i), .ex_mem_re_i(ex_mem_re_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_data_o(wb_rd_data_o), .wb_rd_wen_o(wb_rd_wen_o),
        .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load: request edge, ack cycle, completion edge; leaves inputs idle.
    task automatic zw_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
        ex_mem_size_i = sz;
        ex_mem_addr_i = a;
        ex_mem_re_i   = 1'b1;
        ex_rd_addr_i  = 5'd9;
        ex_rd_wen_i   = 1'b1;
        step();
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = rd;
        step();
        dbus_ack_i  = 1'b0;
        ex_mem_re_i = 1'b0;
        ex_rd_wen_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'd0; ex_rd_wen_i = 1'b0;
        ex_mem_addr_i = 32'd0; ex_mem_data_i = 32'd0; ex_mem_size_i = 3'd0;
        ex_mem_we_i = 1'b0; ex_mem_re_i = 1'b0;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'd0;
        step(); step();
        chk1("rst_req", dbus_req_o, 1'b0);
        chk1("rst_wen", wb_rd_wen_o, 1'b0);
        chk32("rst_wdata", wb_rd_data_o, 32'd0);
        chk1("rst_hold", hold_flag_o, 1'b0);
        chk1("rst_err", bus_err_o, 1'b0);
        rst = 1'b0;

        // ALU result passes through with one cycle latency
        ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h1234; ex_rd_wen_i = 1'b1;
        #1 chk1("alu_hold", hold_flag_o, 1'b0);
        step();
        chk32("alu_addr", 32'(wb_rd_addr_o), 32'd5);
        chk32("alu_data", wb_rd_data_o, 32'h1234);
        chk1("alu_wen", wb_rd_wen_o, 1'b1);
        chk1("alu_req", dbus_req_o, 1'b0);
        ex_rd_wen_i = 1'b0;
        step();

        // SB 0x103 with ack arriving in the third BUSY cycle
        ex_mem_addr_i = 32'h103; ex_mem_data_i = 32'hAB; ex_mem_size_i = 3'b000; ex_mem_we_i = 1'b1;
        #1 chk1("sb_hold_idle", hold_flag_o, 1'b1);
        step();
        chk1("sb_req1", dbus_req_o, 1'b1);
        chk1("sb_we", dbus_we_o, 1'b1);
        chk32("sb_be", 32'(dbus_be_o), 32'h8);
        chk32("sb_wdata", dbus_wdata_o, 32'hABABABAB);
        chk32("sb_addr", dbus_addr_o, 32'h100);
        chk1("sb_wen_bubble", wb_rd_wen_o, 1'b0);
        chk1("sb_hold1", hold_flag_o, 1'b1);
        step();
        chk1("sb_req2", dbus_req_o, 1'b1);
        chk1("sb_hold2", hold_flag_o, 1'b1);
        step();
        chk1("sb_req3", dbus_req_o, 1'b1);
        dbus_ack_i = 1'b1;
        #1 chk1("sb_hold_ack", hold_flag_o, 1'b0);
        step();
        dbus_ack_i = 1'b0; ex_mem_we_i = 1'b0;
        chk1("sb_req_drop", dbus_req_o, 1'b0);
        chk1("sb_wen", wb_rd_wen_o, 1'b0);
        step();

        // SH 0x102 and SW 0x104 lane placement, zero-wait ack
        ex_mem_addr_i = 32'h102; ex_mem_data_i = 32'h1234ABCD; ex_mem_size_i = 3'b001; ex_mem_we_i = 1'b1;
        step();
        chk32("sh_be", 32'(dbus_be_o), 32'hC);
        chk32("sh_wdata", dbus_wdata_o, 32'hABCDABCD);
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0; ex_mem_we_i = 1'b0;
        step();
        ex_mem_addr_i = 32'h104; ex_mem_data_i = 32'hDEADBEEF; ex_mem_size_i = 3'b010; ex_mem_we_i = 1'b1;
        step();
        chk32("sw_be", 32'(dbus_be_o), 32'hF);
        chk32("sw_wdata", dbus_wdata_o, 32'hDEADBEEF);
        chk32("sw_addr", dbus_addr_o, 32'h104);
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0; ex_mem_we_i = 1'b0;
        step();

        // Load extraction and extension
        zw_load(3'b000, 32'h102, 32'h00800000);
        chk32("lb_data", wb_rd_data_o, 32'hFFFFFF80);
        chk1("lb_wen", wb_rd_wen_o, 1'b1);
        chk32("lb_rd", 32'(wb_rd_addr_o), 32'd9);
        step();
        zw_load(3'b100, 32'h102, 32'h00800000);
        chk32("lbu_data", wb_rd_data_o, 32'h00000080);
        step();
        zw_load(3'b001, 32'h102, 32'hBEEF0000);
        chk32("lh_data", wb_rd_data_o, 32'hFFFFBEEF);
        step();
        zw_load(3'b101, 32'h102, 32'hBEEF0000);
        chk32("lhu_data", wb_rd_data_o, 32'h0000BEEF);
        step();
        zw_load(3'b000, 32'h101, 32'h00007F00);
        chk32("lb_pos_data", wb_rd_data_o, 32'h0000007F);
        step();
        zw_load(3'b111, 32'h100, 32'h12345678);
        chk32("undef_size_data", wb_rd_data_o, 32'h12345678);
        step();

        // LW timeout after four unacknowledged BUSY cycles
        ex_mem_addr_i = 32'h200; ex_mem_size_i = 3'b010; ex_mem_re_i = 1'b1;
        ex_rd_addr_i = 5'd3; ex_rd_wen_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("to_req", dbus_req_o, 1'b1);
            chk1("to_hold", hold_flag_o, (i < 3) ? 1'b1 : 1'b0);
            if (i < 3) step();
        end
        step();
        ex_mem_re_i = 1'b0; ex_rd_wen_i = 1'b0;
        chk1("to_req_drop", dbus_req_o, 1'b0);
        chk1("to_err", bus_err_o, 1'b1);
        chk32("to_data", wb_rd_data_o, 32'd0);
        chk1("to_wen", wb_rd_wen_o, 1'b1);
        chk32("to_rd", 32'(wb_rd_addr_o), 32'd3);
        step();
        chk1("to_err_pulse", bus_err_o, 1'b0);

        // Reset during the second BUSY cycle, with an ack that must be ignored
        ex_rd_data_i = 32'hCAFE; ex_rd_wen_i = 1'b1;
        step();
        chk32("pre_rst_data", wb_rd_data_o, 32'hCAFE);
        ex_mem_addr_i = 32'h300; ex_mem_size_i = 3'b010; ex_mem_re_i = 1'b1;
        step();
        step();
        chk1("mid_req", dbus_req_o, 1'b1);
        rst = 1'b1; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h55AA55AA;
        step();
        ex_mem_re_i = 1'b0; ex_rd_wen_i = 1'b0; dbus_ack_i = 1'b0;
        chk1("mrst_req", dbus_req_o, 1'b0);
        chk32("mrst_data", wb_rd_data_o, 32'd0);
        chk1("mrst_wen", wb_rd_wen_o, 1'b0);
        #1 chk1("mrst_hold", hold_flag_o, 1'b0);
        rst = 1'b0;
        step();

        // Misaligned word load
        ex_mem_addr_i = 32'h102; ex_mem_size_i = 3'b010; ex_mem_re_i = 1'b1;
        ex_rd_addr_i = 5'd4; ex_rd_wen_i = 1'b1;
`ifdef MEM_MISALIGN_CHK_EN
        #1 chk1("mis_hold", hold_flag_o, 1'b0);
        step();
        ex_mem_re_i = 1'b0; ex_rd_wen_i = 1'b0;
        chk1("mis_req", dbus_req_o, 1'b0);
        chk1("mis_flag", misalign_o, 1'b1);
        chk32("mis_addr", misalign_addr_o, 32'h102);
        chk1("mis_wen", wb_rd_wen_o, 1'b0);
        step();
        chk1("mis_pulse", misalign_o, 1'b0);
`else
        #1 chk1("nochk_hold", hold_flag_o, 1'b1);
        step();
        chk1("nochk_req", dbus_req_o, 1'b1);
        chk32("nochk_addr", dbus_addr_o, 32'h100);
        chk32("nochk_be", 32'(dbus_be_o), 32'hF);
        chk1("nochk_flag", misalign_o, 1'b0);
        chk32("nochk_maddr", misalign_addr_o, 32'd0);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hA5A5A5A5;
        step();
        dbus_ack_i = 1'b0; ex_mem_re_i = 1'b0; ex_rd_wen_i = 1'b0;
        chk32("nochk_data", wb_rd_data_o, 32'hA5A5A5A5);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
